// File: rtl/gpr_pkg.sv
// Shared constants and helpers for the multi-port GPR file with scoreboard.
package gpr_pkg;

  // Default register geometry for the MIPS datapath.
  localparam int N_DEF    = 32;
  localparam int NREG_DEF = 32;

  // Index of the hardwired-zero register.
  localparam int REG_ZERO = 0;

  // Width needed to hold a count of 0..nreg busy registers.
  function automatic int cnt_width(input int nreg);
    return $clog2(nreg + 1);
  endfunction

endpackage

// File: rtl/gpr_wr_select.sv
// Per-register write-port arbiter: the highest-index port that targets
// REG_IDX wins. One instance per register feeds both the storage update
// and the read bypass path, so the two can never disagree on the winner.
module gpr_wr_select
  import gpr_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int K       = 5,
  parameter int NWR     = 2,
  parameter int REG_IDX = 1
) (
  input  logic [NWR-1:0]   i_wren,
  input  logic [NWR*K-1:0] i_wr_addr,
  input  logic [NWR*N-1:0] i_wr_data,
  output logic             o_we,
  output logic [N-1:0]     o_data
);

  logic [NWR-1:0] w_hit;
  logic           w_we;
  logic [N-1:0]   w_data;

  // Flag every port whose enabled write targets this register.
  always_comb begin
    w_hit = '0;
    for (int j = 0; j < NWR; j++) begin
      w_hit[j] = i_wren[j] && (i_wr_addr[j*K +: K] == K'(REG_IDX));
    end
  end

  // Scan low to high so a later (higher-index) hit overrides earlier ones.
  always_comb begin
    w_we   = 1'b0;
    w_data = '0;
    for (int j = 0; j < NWR; j++) begin
      if (w_hit[j]) begin
        w_we   = 1'b1;
        w_data = i_wr_data[j*N +: N];
      end else begin
        w_we   = w_we;
        w_data = w_data;
      end
    end
  end

  assign o_we   = w_we;
  assign o_data = w_data;

endmodule

// File: rtl/gpr_mp_sb.sv
// Multi-port GPR file with write-to-read bypass and a per-register busy
// scoreboard. Decode reads operands plus hazard flags; writeback ports
// retire results and clear the matching busy bits.
module gpr_mp_sb
  import gpr_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int K      = $clog2(NREG),
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NWR-1:0]               wren,
  input  logic [NWR*K-1:0]             wr_addr,
  input  logic [NWR*N-1:0]             wr_data,
  input  logic [NRD*K-1:0]             rd_addr,
  output logic [NRD*N-1:0]             rd_data,
  output logic [NRD-1:0]               rd_busy,
  input  logic                         issue_en,
  input  logic [K-1:0]                 issue_addr,
  input  logic                         flush,
  output logic                         issue_stall,
  output logic [cnt_width(NREG)-1:0]   busy_cnt
);

  localparam int CW = cnt_width(NREG);

  // Architectural state.
  logic [N-1:0]    r_regs [NREG];
  logic [NREG-1:0] r_busy;

  // Resolved per-register write enables/data and next busy vector.
  logic [NREG-1:0] w_we;
  logic [N-1:0]    w_wdata [NREG];
  logic [NREG-1:0] w_busy_nxt;
  logic [K-1:0]    w_ra [NRD];

  // Register 0 never takes a write, so it never bypasses or clears busy.
  assign w_we[0]    = 1'b0;
  assign w_wdata[0] = '0;

  generate
    for (genvar g = 1; g < NREG; g++) begin : g_sel
      gpr_wr_select #(
        .N       (N),
        .K       (K),
        .NWR     (NWR),
        .REG_IDX (g)
      ) u_sel (
        .i_wren    (wren),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .o_we      (w_we[g]),
        .o_data    (w_wdata[g])
      );
    end

    for (genvar i = 0; i < NRD; i++) begin : g_ra
      assign w_ra[i] = rd_addr[i*K +: K];
    end
  endgenerate

  // Storage update: load each register from its winning write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      r_regs[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (w_we[r]) begin
          r_regs[r] <= w_wdata[r];
        end
      end
    end
  end

  // Busy next state: new issue beats flush, flush beats writeback clear.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 0; r < NREG; r++) begin
      if (r == REG_ZERO) begin
        w_busy_nxt[r] = 1'b0;
      end else if (issue_en && (issue_addr == K'(r))) begin
        w_busy_nxt[r] = 1'b1;
      end else if (flush) begin
        w_busy_nxt[r] = 1'b0;
      end else if (w_we[r]) begin
        w_busy_nxt[r] = 1'b0;
      end else begin
        w_busy_nxt[r] = r_busy[r];
      end
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Read ports: forward same-cycle write data (if enabled) else stored value;
  // a forwarded operand is no longer waiting on its producer.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (!rst) begin
        rd_data[i*N +: N] = '0;
        rd_busy[i]        = 1'b0;
      end else if ((BYPASS != 0) && w_we[w_ra[i]]) begin
        rd_data[i*N +: N] = w_wdata[w_ra[i]];
        rd_busy[i]        = 1'b0;
      end else begin
        rd_data[i*N +: N] = r_regs[w_ra[i]];
        rd_busy[i]        = r_busy[w_ra[i]];
      end
    end
  end

  // WAW hint: destination still busy and not being retired or squashed now.
  always_comb begin
    if (!rst) begin
      issue_stall = 1'b0;
    end else begin
      issue_stall = issue_en
                 && (issue_addr != K'(REG_ZERO))
                 && r_busy[issue_addr]
                 && !w_we[issue_addr]
                 && !flush;
    end
  end

  // Population count of the registered busy vector.
  always_comb begin
    busy_cnt = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_cnt = busy_cnt + CW'(r_busy[r]);
    end
  end

endmodule

// File: tb/tb_gpr_mp_sb.sv
// Directed bench for gpr_mp_sb: one instance with bypass, one without,
// sharing the same stimulus; expected values are hand-computed constants.
module tb_gpr_mp_sb;

  localparam int N    = 32;
  localparam int NREG = 32;
  localparam int K    = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int CW   = 6;

  logic             clk;
  logic             rst;
  logic [NWR-1:0]   wren;
  logic [NWR*K-1:0] wr_addr;
  logic [NWR*N-1:0] wr_data;
  logic [NRD*K-1:0] rd_addr;
  logic             issue_en;
  logic [K-1:0]     issue_addr;
  logic             flush;

  logic [NRD*N-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]   rd_busy_b, rd_busy_n;
  logic             stall_b, stall_n;
  logic [CW-1:0]    cnt_b, cnt_n;

  int n_vec = 0;
  int n_err = 0;

  gpr_mp_sb #(.N(N), .NREG(NREG), .K(K), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_dut_b (
    .clk(clk), .rst(rst), .wren(wren), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
    .issue_stall(stall_b), .busy_cnt(cnt_b)
  );

  gpr_mp_sb #(.N(N), .NREG(NREG), .K(K), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_dut_n (
    .clk(clk), .rst(rst), .wren(wren), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
    .issue_stall(stall_n), .busy_cnt(cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wren       = '0;
    wr_addr    = '0;
    wr_data    = '0;
    issue_en   = 1'b0;
    issue_addr = '0;
    flush      = 1'b0;
  endtask

  task automatic wr(input int p, input logic [K-1:0] a, input logic [N-1:0] d);
    wren[p]          = 1'b1;
    wr_addr[p*K +: K] = a;
    wr_data[p*N +: N] = d;
  endtask

  task automatic rd(input int p, input logic [K-1:0] a);
    rd_addr[p*K +: K] = a;
  endtask

  task automatic issue(input logic [K-1:0] a);
    issue_en   = 1'b1;
    issue_addr = a;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    rd_addr = '0;
    idle();
    #2;
    // Reset: outputs forced low even with a write in flight.
    wr(0, 5'd5, 32'h55); rd(0, 5'd5);
    #1;
    chk("rst_rd0_b", rd_data_b[0 +: N], 32'h0);
    chk("rst_busy",  {30'd0, rd_busy_b}, 32'h0);
    chk("rst_cnt",   {26'd0, cnt_b}, 32'h0);
    chk("rst_stall", {31'd0, stall_b}, 32'h0);
    idle();
    tick();
    rst = 1'b1;

    // Write to r0 is ignored and never bypassed.
    wr(0, 5'd0, 32'hDEADBEEF); rd(0, 5'd0);
    #1 chk("r0_bypass", rd_data_b[0 +: N], 32'h0);
    tick(); idle();
    #1 chk("r0_read", rd_data_b[0 +: N], 32'h0);

    // Priority: both ports to r5, port1 wins.
    wr(0, 5'd5, 32'h11); wr(1, 5'd5, 32'h22); rd(0, 5'd5);
    #1;
    chk("prio_byp_b", rd_data_b[0 +: N], 32'h22);
    chk("prio_byp_n", rd_data_n[0 +: N], 32'h0);
    tick(); idle();
    #1;
    chk("prio_b", rd_data_b[0 +: N], 32'h22);
    chk("prio_n", rd_data_n[0 +: N], 32'h22);

    // Two ports, different registers.
    wr(0, 5'd3, 32'h3); wr(1, 5'd4, 32'h4);
    tick(); idle(); rd(0, 5'd3); rd(1, 5'd4);
    #1;
    chk("dual_r3", rd_data_b[0 +: N], 32'h3);
    chk("dual_r4", rd_data_n[N +: N], 32'h4);

    // Bypass vs no bypass on r7.
    wr(0, 5'd7, 32'hCAFE); rd(0, 5'd7);
    #1;
    chk("byp7_b", rd_data_b[0 +: N], 32'hCAFE);
    chk("byp7_n", rd_data_n[0 +: N], 32'h0);
    tick(); idle();
    #1 chk("byp7_n_next", rd_data_n[0 +: N], 32'hCAFE);

    // Scoreboard: issue r9; same-cycle issue does not show on rd_busy.
    issue(5'd9); rd(0, 5'd9);
    #1 chk("iss_same_busy", {31'd0, rd_busy_b[0]}, 32'h0);
    tick(); idle();
    #1;
    chk("iss_busy", {31'd0, rd_busy_b[0]}, 32'h1);
    chk("iss_cnt",  {26'd0, cnt_b}, 32'h1);
    // Writeback on port1 masks busy with bypass, not without.
    wr(1, 5'd9, 32'h99);
    #1;
    chk("wb_busy_b", {31'd0, rd_busy_b[0]}, 32'h0);
    chk("wb_busy_n", {31'd0, rd_busy_n[0]}, 32'h1);
    tick(); idle();
    #1;
    chk("wb_cnt_b",  {26'd0, cnt_b}, 32'h0);
    chk("wb_busy_n2", {31'd0, rd_busy_n[0]}, 32'h0);

    // Issue and writeback to r9 together: issue wins.
    issue(5'd9); wr(0, 5'd9, 32'h1);
    #1 chk("simul_stall", {31'd0, stall_b}, 32'h0);
    tick(); idle();
    #1;
    chk("simul_cnt",  {26'd0, cnt_b}, 32'h1);
    chk("simul_busy", {31'd0, rd_busy_b[0]}, 32'h1);
    // Re-issue while busy: WAW stall.
    issue(5'd9);
    #1 chk("waw_stall", {31'd0, stall_n}, 32'h1);
    tick(); idle();
    // Issue to r0 is a no-op.
    issue(5'd0);
    #1 chk("r0_stall", {31'd0, stall_b}, 32'h0);
    tick(); idle();
    #1 chk("r0_cnt", {26'd0, cnt_b}, 32'h1);

    // Flush: r2, r3, r4 busy (plus r9), then flush with issue r6.
    issue(5'd2); tick();
    issue(5'd3); tick();
    issue(5'd4); tick(); idle();
    #1 chk("pre_flush_cnt", {26'd0, cnt_b}, 32'h4);
    flush = 1'b1; issue(5'd6);
    tick(); idle(); rd(0, 5'd6); rd(1, 5'd2);
    #1;
    chk("flush_cnt",  {26'd0, cnt_n}, 32'h1);
    chk("flush_r6",   {31'd0, rd_busy_b[0]}, 32'h1);
    chk("flush_r2",   {31'd0, rd_busy_b[1]}, 32'h0);

    // Asynchronous reset mid-run clears everything at once.
    rd(0, 5'd5); rd(1, 5'd7);
    #1;
    chk("pre_rst_r5", rd_data_b[0 +: N], 32'h22);
    chk("pre_rst_r7", rd_data_b[N +: N], 32'hCAFE);
    rst = 1'b0;
    #1;
    chk("async_r5",  rd_data_b[0 +: N], 32'h0);
    chk("async_r7",  rd_data_n[N +: N], 32'h0);
    chk("async_cnt", {26'd0, cnt_b}, 32'h0);
    tick();
    rst = 1'b1;
    wr(0, 5'd0, 32'hDEADBEEF);
    tick(); idle(); rd(0, 5'd0); rd(1, 5'd5);
    #1;
    chk("post_rst_r0", rd_data_b[0 +: N], 32'h0);
    chk("post_rst_r5", rd_data_b[N +: N], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpr_mp_sb.md
Name: gpr_mp_sb

Overview:
- Multi-port general-purpose register file for the pipelined multi-core MIPS datapath.
- Generalises the single-write, two-read GPR in two directions:
  - parametrised read and write port counts;
  - write-to-read bypass, plus a per-register busy scoreboard (set at issue, cleared at writeback).
- Decode reads operands and hazard flags from it; writeback ports retire results into it.

Parameters:
- N, 32, data width per register.
- NREG, 32, number of registers; register 0 is hardwired to zero.
- K, $clog2(NREG), address width.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports; higher index has higher priority.
- BYPASS, 1, 1 = same-cycle write data is forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- wren  input  NWR  per-port write enable.
- wr_addr  input  NWR*K  write addresses, port j at [j*K +: K].
- wr_data  input  NWR*N  write data, port j at [j*N +: N].
- rd_addr  input  NRD*K  read addresses.
- rd_data  output  NRD*N  read data, combinational.
- rd_busy  output  NRD  source register still has a pending producer.
- issue_en  input  1  claim a destination register.
- issue_addr  input  K  destination register being claimed.
- flush  input  1  clear all busy bits (pipeline squash).
- issue_stall  output  1  issue_en targets a register that stays busy this cycle (WAW hazard).
- busy_cnt  output  $clog2(NREG+1)  number of busy registers, from the registered state.

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, all busy bits = 0.
  - Outputs during reset: rd_data=0, rd_busy=0, issue_stall=0, busy_cnt=0.
  - rst deasserts synchronously to clk externally; the first edge after deassertion is a normal edge.
- Register 0:
  - writes to it are ignored; it reads 0; it is never busy;
  - issue to it is a no-op, and issue_stall=0 for it.
- Write, rising edge:
  - register r loads the data of the highest-index port j with wren[j] and wr_addr[j]==r;
  - lower-priority writes to the same r are dropped;
  - latency is 1 cycle to storage.
- Read, combinational:
  - BYPASS=1 and some port writes rd_addr[i] this cycle: rd_data[i] = winning wr_data.
  - Otherwise: rd_data[i] = stored value.
  - Bypass never applies to address 0.
- Busy scoreboard, next state for register r, in priority order:
  1. issue_en && issue_addr==r && r!=0 -> 1 (a new producer beats a same-cycle writeback and flush);
  2. flush -> 0;
  3. any wren[j] with wr_addr[j]==r -> 0;
  4. otherwise hold.
- rd_busy[i]:
  - = busy[rd_addr[i]], masked to 0 if BYPASS=1 and a write to that address occurs this cycle;
  - with BYPASS=0, the register stays busy until the cycle after its write;
  - always 0 for address 0;
  - not affected by a same-cycle issue.
- issue_stall = issue_en && issue_addr!=0 && busy[issue_addr] && no same-cycle write to issue_addr && !flush.
  - It is advisory only: the busy bit is still set if the issue proceeds.
- busy_cnt = popcount of the registered busy vector; it reflects updates one cycle after the edge.

Decomposition:
- Shared package gpr_pkg:
  - default N/NREG constants and the REG_ZERO=0 constant;
  - the function that computes the busy_cnt width.
- Sub-module gpr_wr_select:
  - per register, resolves the NWR-way priority into a single write enable and data;
  - used for both storage and bypass.
- Storage and scoreboard stay in the top level.

Test Plan:
- Reset and zero register:
  - assert rst=0 mid-run after writes -> all rd_data=0 and busy_cnt=0 immediately, without waiting for a clock edge;
  - after release, write r0=0xDEADBEEF -> r0 still reads 0.
- Priority:
  - wren=2'b11 with both ports to r5, port0=0x11, port1=0x22 -> next cycle r5 reads 0x22;
  - both ports to different regs r3=0x3, r4=0x4 -> both stored.
- Bypass:
  - BYPASS=1: write r7=0xCAFE while rd_addr[0]=7 -> rd_data[0]=0xCAFE in the same cycle;
  - BYPASS=0: same stimulus -> old value this cycle, 0xCAFE the next.
- Scoreboard:
  - issue r9 -> rd_busy=1 on read of r9 and busy_cnt=1;
  - write r9 on port1 -> rd_busy=0 in that cycle (BYPASS=1);
  - after the edge, busy_cnt=0.
- Simultaneous events:
  - issue r9 and write r9 in the same cycle -> r9 busy afterwards;
  - issue r9 again while busy, no write -> issue_stall=1.
- Flush:
  - busy on r2, r3, r4, then flush with issue r6 -> afterwards only r6 busy and busy_cnt=1.
